// File: rtl/btn_debouncer.sv
// Push-button debouncer: synchronises an asynchronous button level, qualifies it
// over STABLE_CYCLES consecutive cycles and emits registered press/release strobes.
module btn_debouncer #(
    parameter int unsigned STABLE_CYCLES = 25000,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic btn,
    output logic btn_deb,
    output logic btn_press,
    output logic btn_release
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   btn_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   deb_r;
    logic                   deb_nxt_s;
    logic                   press_r;
    logic                   press_nxt_s;
    logic                   release_r;
    logic                   release_nxt_s;

    // Metastability chain; only the last stage is used downstream
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], btn};
        end
    end

    assign btn_s = sync_r[SYNC_STAGES-1];

    // Qualification counter and next debounced level / strobes
    always_comb begin
        cnt_nxt_s     = CNT_ZERO;
        deb_nxt_s     = deb_r;
        press_nxt_s   = 1'b0;
        release_nxt_s = 1'b0;
        if (btn_s == deb_r) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (cnt_r < CNT_MAX) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
            // Also recovers from an out-of-range count by forcing the toggle
            cnt_nxt_s     = CNT_ZERO;
            deb_nxt_s     = btn_s;
            press_nxt_s   = btn_s;
            release_nxt_s = ~btn_s;
        end
    end

    // State and output registers
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= CNT_ZERO;
            deb_r     <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            deb_r     <= deb_nxt_s;
            press_r   <= press_nxt_s;
            release_r <= release_nxt_s;
        end
    end

    assign btn_deb     = deb_r;
    assign btn_press   = press_r;
    assign btn_release = release_r;

endmodule

// File: tb/tb_btn_debouncer.sv
// Bench for btn_debouncer: per-cycle vector tables on a short-window instance,
// plus an event scoreboard on a scaled long-level instance.
module tb_btn_debouncer;

    localparam int STABLE_A = 8;
    localparam int STABLE_B = 250;
    localparam int SYNC_B   = 3;
    localparam int LAT_B    = SYNC_B - 1 + STABLE_B;

    logic sysclk = 1'b0;
    logic rst_n, rst_n_b, btn_a, btn_b;
    logic deb_a, press_a, rel_a;
    logic deb_b, press_b, rel_b;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic b;
        logic d;
        logic p;
        logic r;
    } vec_t;

    typedef struct {
        int   cyc;
        logic press;
    } evt_t;

    vec_t tbl[$];
    vec_t sb_q[$];
    evt_t evt_q[$];

    always #5 sysclk = ~sysclk;

    btn_debouncer #(.STABLE_CYCLES(STABLE_A), .SYNC_STAGES(2)) dut_a (
        .sysclk(sysclk), .rst_n(rst_n), .btn(btn_a),
        .btn_deb(deb_a), .btn_press(press_a), .btn_release(rel_a)
    );

    btn_debouncer #(.STABLE_CYCLES(STABLE_B), .SYNC_STAGES(SYNC_B)) dut_b (
        .sysclk(sysclk), .rst_n(rst_n_b), .btn(btn_b),
        .btn_deb(deb_b), .btn_press(press_b), .btn_release(rel_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic b, input int n, input logic d);
        vec_t v;
        v.b = b; v.d = d; v.p = 1'b0; v.r = 1'b0;
        repeat (n) tbl.push_back(v);
    endtask

    task automatic add1(input logic b, input logic d, input logic p, input logic r);
        vec_t v;
        v.b = b; v.d = d; v.p = p; v.r = r;
        tbl.push_back(v);
    endtask

    // Drive one vector per clock, queue its expectation, compare after the edge
    task automatic run_table(input string name);
        vec_t e;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge sysclk);
            btn_a = tbl[i].b;
            sb_q.push_back(tbl[i]);
            @(posedge sysclk);
            #1;
            e = sb_q.pop_front();
            check($sformatf("%s[%0d] deb/press/rel", name, i),
                  {29'd0, deb_a, press_a, rel_a}, {29'd0, e.d, e.p, e.r});
        end
        tbl.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        evt_t e;
        logic lvl;
        int   n_press;
        int   n_rel;
        n_press = 0;
        n_rel   = 0;
        rst_n   = 1'b1;
        rst_n_b = 1'b1;
        btn_a   = 1'b0;
        btn_b   = 1'b0;
        #2;
        rst_n   = 1'b0;
        rst_n_b = 1'b0;
        #1;
        check("reset_state", {29'd0, deb_a, press_a, rel_a}, 32'd0);
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        rst_n   = 1'b1;
        rst_n_b = 1'b1;

        // Idle low
        add(1'b0, 100, 1'b0);
        run_table("idle");

        // Short glitches, including the longest one that must still be rejected
        add(1'b1, 5, 1'b0); add(1'b0, 10, 1'b0);
        run_table("glitch5");
        add(1'b1, 7, 1'b0); add(1'b0, 10, 1'b0);
        run_table("glitch7");

        // Clean press: level appears after edge k+9
        add(1'b1, 9, 1'b0); add1(1'b1, 1'b1, 1'b1, 1'b0); add(1'b1, 5, 1'b1);
        run_table("press");

        // Bouncy release: only the final low run qualifies
        add(1'b0, 3, 1'b1); add(1'b1, 2, 1'b1); add(1'b0, 4, 1'b1); add(1'b1, 1, 1'b1);
        add(1'b0, 9, 1'b1); add1(1'b0, 1'b0, 1'b0, 1'b1); add(1'b0, 5, 1'b0);
        run_table("bounce_release");

        // Reset mid-qualification discards the partial count
        add(1'b1, 7, 1'b0);
        run_table("pre_rst");
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_count", {29'd0, deb_a, press_a, rel_a}, 32'd0);
        @(posedge sysclk);
        #1;
        check("rst_held", {29'd0, deb_a, press_a, rel_a}, 32'd0);
        @(posedge sysclk);
        #2;
        rst_n = 1'b1;
        add(1'b1, 9, 1'b0); add1(1'b1, 1'b1, 1'b1, 1'b0); add(1'b1, 3, 1'b1);
        run_table("post_rst");

        // Reset while high clears the level at once and produces no release strobe
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_clear", {29'd0, deb_a, press_a, rel_a}, 32'd0);
        @(posedge sysclk);
        #1;
        check("rst_no_strobe", {29'd0, deb_a, press_a, rel_a}, 32'd0);
        @(posedge sysclk);
        #2;
        rst_n = 1'b1;
        add(1'b0, 12, 1'b0);
        run_table("after_rst_low");

        // Scaled long-level run: glitch, high 2x, low 3x, then high held
        for (int c = 0; c < 1870; c++) begin
            @(negedge sysclk);
            lvl   = (c < 5) || (c >= 20 && c < 520) || (c >= 1270);
            btn_b = lvl;
            if (c == 20 || c == 1270 || c == 520) begin
                e.cyc   = c + LAT_B;
                e.press = (c != 520);
                evt_q.push_back(e);
            end
            @(posedge sysclk);
            #1;
            if (press_b || rel_b) begin
                if (press_b) n_press++;
                else n_rel++;
                if (evt_q.size() == 0) begin
                    check($sformatf("long_unexpected_strobe@%0d", c), {30'd0, press_b, rel_b}, 32'd0);
                end else begin
                    e = evt_q.pop_front();
                    check("long_event_cycle", c, e.cyc);
                    check("long_event_kind", {29'd0, deb_b, press_b, rel_b},
                          {29'd0, e.press, e.press, ~e.press});
                end
            end else if (evt_q.size() > 0 && evt_q[0].cyc < c) begin
                e = evt_q.pop_front();
                check("long_missing_strobe_at", c, e.cyc);
            end
        end
        check("long_press_count", n_press, 2);
        check("long_release_count", n_rel, 1);
        check("long_final_level", {31'd0, deb_b}, 32'd1);
        check("long_events_left", evt_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
